// File: rtl/dtc_vote_accum.sv
// Temporal majority voter behind a decision-tree classifier. It accumulates per-bit hits
// over a window of WINDOW samples, or fewer if flushed, and emits one voted vector per window.
// Latency: out_valid rises 1 cycle after the closing accept or flush.
// Backpressure: in_ready=0 while a result is held; the result waits until out_ready.
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      sample handshake; in_vec is the classifier prediction vector
//   flush                  closes the current window early (ignored while holding a result)
//   out_valid/out_ready    result handshake; out_vec is the voted vector, out_n the window size
module dtc_vote_accum #(
   parameter int OUT_W   = 18,
   parameter int WINDOW  = 8,
   parameter int CNT_W   = $clog2(WINDOW + 1),
   parameter bit TIE_SET = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OUT_W-1:0] in_vec,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_vec,
   output logic [CNT_W-1:0] out_n
);

   typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

   state_t                      state;
   state_t                      state_nx;
   logic [CNT_W-1:0]            n;
   logic [OUT_W-1:0][CNT_W-1:0] cnt;

   logic                        acc;
   logic                        close_win;
   logic                        release_win;
   logic [CNT_W-1:0]            n_f;
   logic [OUT_W-1:0][CNT_W-1:0] cnt_f;
   logic [OUT_W-1:0]            vote;

   assign acc         = in_valid && in_ready;
   assign release_win = (state == HOLD) && out_ready;

   // A window closes when this accept fills it, or when a flush arrives and the
   // window holds at least one sample (counting a sample accepted this cycle).
   assign close_win = (state == ACCUM) &&
                      ((acc && (n == CNT_W'(WINDOW - 1))) ||
                       (flush && ((n != '0) || acc)));

   // Closing totals include the sample accepted this cycle, so the vote
   // is ready on the same edge that enters HOLD.
   always_comb begin
      n_f   = n + CNT_W'(acc);
      cnt_f = '0;
      vote  = '0;
      for (int i = 0; i < OUT_W; i++) begin
         cnt_f[i] = cnt[i] + CNT_W'(acc & in_vec[i]);
         // Compare 2*cnt_f against n_f at CNT_W+1 bits so the doubling cannot wrap.
         vote[i]  = ({cnt_f[i], 1'b0} > {1'b0, n_f}) ||
                    (({cnt_f[i], 1'b0} == {1'b0, n_f}) && TIE_SET);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ACCUM;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ACCUM:   if (close_win)   state_nx = HOLD;
         HOLD:    if (release_win) state_nx = ACCUM;
         default: state_nx = ACCUM;
      endcase
   end

   // Output decode; in_ready depends only on state, never on out_ready.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ACCUM:   in_ready  = 1'b1;
         HOLD:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   // Datapath: counters and the held result.
   always_ff @(posedge clk) begin
      if (rst) begin
         n       <= '0;
         cnt     <= '0;
         out_vec <= '0;
         out_n   <= '0;
      end else begin
         if (close_win) begin
            out_vec <= vote;
            out_n   <= n_f;
         end
         if (release_win) begin
            n   <= '0;
            cnt <= '0;
         end else if (acc) begin
            // Counters never exceed WINDOW: a full window closes and stalls accepts.
            n   <= n_f;
            cnt <= cnt_f;
         end
      end
   end

endmodule

// File: tb/tb_dtc_vote_accum.sv
module tb_dtc_vote_accum;

   localparam int OUT_W  = 18;
   localparam int WINDOW = 8;
   localparam int CNT_W  = $clog2(WINDOW + 1);

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic [OUT_W-1:0] in_vec;
   logic             flush;
   logic             out_ready;
   logic             in_ready0,  in_ready1;
   logic             out_valid0, out_valid1;
   logic [OUT_W-1:0] out_vec0,   out_vec1;
   logic [CNT_W-1:0] out_n0,     out_n1;

   // Two instances share stimulus; they differ only in how ties are voted.
   dtc_vote_accum #(.OUT_W(OUT_W), .WINDOW(WINDOW), .TIE_SET(1'b0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_vec(in_vec),
      .flush(flush), .out_valid(out_valid0), .out_ready(out_ready), .out_vec(out_vec0),
      .out_n(out_n0));

   dtc_vote_accum #(.OUT_W(OUT_W), .WINDOW(WINDOW), .TIE_SET(1'b1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_vec(in_vec),
      .flush(flush), .out_valid(out_valid1), .out_ready(out_ready), .out_vec(out_vec1),
      .out_n(out_n1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   // Reference model: the open window is a list of samples, the vote is a head count.
   logic [OUT_W-1:0] win_q[$];
   bit               m_hold = 1'b0;
   logic [OUT_W-1:0] m_vec0 = '0;
   logic [OUT_W-1:0] m_vec1 = '0;
   int               m_n    = 0;
   int               n_acc  = 0;
   int               dut_hs = 0;
   int               dut_sum = 0;

   function automatic logic [OUT_W-1:0] vote_of(input bit tie);
      logic [OUT_W-1:0] v;
      int ones;
      int total;
      v = '0;
      total = win_q.size();
      for (int b = 0; b < OUT_W; b++) begin
         ones = 0;
         foreach (win_q[k]) if (win_q[k][b]) ones++;
         v[b] = (2 * ones > total) || ((2 * ones == total) && tie);
      end
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs at the falling edge, advance the model with the
   // inputs in force, then return just after the rising edge.
   task automatic cycle(input bit do_chk);
      @(negedge clk);
      if (do_chk) begin
         chk("in_ready0",  32'(in_ready0),  32'(!m_hold));
         chk("in_ready1",  32'(in_ready1),  32'(!m_hold));
         chk("out_valid0", 32'(out_valid0), 32'(m_hold));
         chk("out_valid1", 32'(out_valid1), 32'(m_hold));
         chk("out_vec0",   32'(out_vec0),   32'(m_vec0));
         chk("out_vec1",   32'(out_vec1),   32'(m_vec1));
         chk("out_n0",     32'(out_n0),     32'(m_n));
         chk("out_n1",     32'(out_n1),     32'(m_n));
         if (!rst && out_valid0 && out_ready) begin
            dut_hs++;
            dut_sum += int'(out_n0);
         end
      end
      if (rst) begin
         win_q.delete();
         m_hold = 1'b0;
         m_vec0 = '0;
         m_vec1 = '0;
         m_n    = 0;
      end else if (!m_hold) begin
         if (in_valid) begin
            win_q.push_back(in_vec);
            n_acc++;
         end
         if ((in_valid && win_q.size() == WINDOW) || (flush && win_q.size() > 0)) begin
            m_vec0 = vote_of(1'b0);
            m_vec1 = vote_of(1'b1);
            m_n    = win_q.size();
            m_hold = 1'b1;
            win_q.delete();
         end
      end else if (out_ready) begin
         m_hold = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic acc_one(input logic [OUT_W-1:0] v, input logic fl);
      in_valid = 1'b1;
      in_vec   = v;
      flush    = fl;
      cycle(1'b1);
      in_valid = 1'b0;
      flush    = 1'b0;
   endtask

   task automatic handshake();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cycle(1'b1);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [OUT_W-1:0] pat_a;
      logic [OUT_W-1:0] pat_b;
      logic [OUT_W-1:0] pat_c;
      int base_acc;
      int base_hs;
      int base_sum;
      int guard;
      int acc_phase;
      int sum_phase;
      int hs_phase;

      pat_a = 18'b100000010101011101;
      pat_b = 18'b100000000000001000;
      pat_c = 18'b011001000000000000;

      rst = 1'b1; in_valid = 1'b0; in_vec = '0; flush = 1'b0; out_ready = 1'b0;

      // 1: reset with random inputs
      for (int c = 0; c < 2; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         flush     = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_vec    = OUT_W'($urandom());
         cycle(c != 0);
      end
      chk("rst_out_valid", 32'(out_valid0), 32'd0);
      chk("rst_in_ready",  32'(in_ready0),  32'd1);
      chk("rst_out_vec",   32'(out_vec0),   32'd0);
      chk("rst_out_n",     32'(out_n0),     32'd0);
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      cycle(1'b1);

      // 2: full window, majority vote
      for (int k = 0; k < 5; k++) acc_one(pat_a, 1'b0);
      for (int k = 0; k < 3; k++) acc_one(pat_b, 1'b0);
      chk("full_valid", 32'(out_valid0), 32'd1);
      chk("full_n",     32'(out_n0),     32'd8);
      chk("full_vec",   32'(out_vec0),   32'(pat_a));
      handshake();
      chk("full_rel_ready", 32'(in_ready0),  32'd1);
      chk("full_rel_valid", 32'(out_valid0), 32'd0);

      // 3: tie vote and backpressure
      for (int k = 0; k < 4; k++) acc_one(18'h00001, 1'b0);
      for (int k = 0; k < 4; k++) acc_one(18'h00000, 1'b0);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_vec   = OUT_W'($urandom());
         cycle(1'b1);
      end
      in_valid = 1'b0;
      chk("tie0_vec",  32'(out_vec0),  32'h00000);
      chk("tie1_vec",  32'(out_vec1),  32'h00001);
      chk("tie_n",     32'(out_n0),    32'd8);
      chk("bp_ready",  32'(in_ready0), 32'd0);
      chk("bp_valid",  32'(out_valid0), 32'd1);
      handshake();

      // 4: flush together with the third accept, then an empty flush
      acc_one(pat_c, 1'b0);
      acc_one(pat_c, 1'b0);
      acc_one(pat_c, 1'b1);
      chk("flush_valid", 32'(out_valid0), 32'd1);
      chk("flush_n",     32'(out_n0),     32'd3);
      chk("flush_vec",   32'(out_vec0),   32'(pat_c));
      handshake();
      flush = 1'b1;
      for (int c = 0; c < 3; c++) cycle(1'b1);
      flush = 1'b0;
      chk("empty_flush_valid", 32'(out_valid0), 32'd0);
      chk("empty_flush_ready", 32'(in_ready0),  32'd1);

      // 5: reset mid-window, then reset while holding
      for (int k = 0; k < 5; k++) acc_one(18'h3ffff, 1'b0);
      rst = 1'b1; in_valid = 1'b1; in_vec = 18'h3ffff;
      cycle(1'b1);
      rst = 1'b0; in_valid = 1'b0;
      for (int k = 0; k < 8; k++) acc_one(OUT_W'($urandom()) & 18'h0ffff, 1'b0);
      chk("rst_mid_n",   32'(out_n0),   32'd8);
      chk("rst_mid_vec", 32'(out_vec0), 32'(m_vec0));
      chk("rst_mid_msb", 32'(out_vec0[17:16]), 32'd0);
      rst = 1'b1;
      cycle(1'b1);
      rst = 1'b0;
      chk("rst_hold_valid", 32'(out_valid0), 32'd0);
      chk("rst_hold_n",     32'(out_n0),     32'd0);
      cycle(1'b1);

      // 6: random throughput against the model
      base_acc = n_acc;
      base_hs  = dut_hs;
      base_sum = dut_sum;
      guard    = 0;
      while ((n_acc - base_acc) < 10000 && guard < 40000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_vec    = OUT_W'($urandom());
         out_ready = 1'($urandom_range(0, 1));
         cycle(1'b1);
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cycle(1'b1);
      cycle(1'b1);
      out_ready = 1'b0;
      chk("thru_budget", 32'((n_acc - base_acc) >= 10000), 32'd1);
      acc_phase = n_acc - base_acc - win_q.size();
      sum_phase = dut_sum - base_sum;
      hs_phase  = dut_hs - base_hs;
      chk("thru_samples", 32'(sum_phase), 32'(acc_phase));
      chk("thru_windows", 32'(hs_phase * WINDOW), 32'(sum_phase));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
